// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-low reset
//   in         - serial data bit, sampled when in_valid=1
//   in_valid   - qualifies in
//   cfg_load   - latches pattern/pat_len/overlap, restarts detection
//   pattern    - target sequence, bit pat_len-1 arrives first, bit 0 last
//   pat_len    - pattern length in bits
//   overlap    - 1 = overlapping matches, 0 = non-overlapping
//   clear      - synchronous clear of match_cnt
//   match      - registered one-cycle pulse per detected occurrence
//   match_cnt  - saturating match count
//   cfg_err    - latched config is illegal, detection disabled
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'(4);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // state registers
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;

  // next-state values
  logic [MAX_LEN-1:0] history_nx;
  logic [LEN_W-1:0]   fill_nx;
  logic [MAX_LEN-1:0] cfg_pattern_nx;
  logic [LEN_W-1:0]   cfg_len_nx;
  logic               cfg_overlap_nx;
  logic               cfg_err_nx;
  logic               match_nx;
  logic [CNT_W-1:0]   match_cnt_nx;

  // combinational helpers
  logic [MAX_LEN-1:0] len_mask_c;
  logic [MAX_LEN-1:0] shifted_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic               hit_c;

  // Mask selecting the low cfg_len bits; higher pattern bits are don't-care.
  always_comb begin
    len_mask_c = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask_c[i] = (LEN_W'(i) < cfg_len);
    end
  end

  // Hit is evaluated on the history as it will look after inserting this bit.
  always_comb begin
    shifted_c  = {history[MAX_LEN-2:0], in};
    fill_inc_c = (fill == FULL_LEN) ? fill : fill + LEN_W'(1);
    hit_c      = in_valid && !cfg_load && !cfg_err &&
                 (fill_inc_c >= cfg_len) &&
                 ((shifted_c & len_mask_c) == (cfg_pattern & len_mask_c));
  end

  // Next-state logic; a load restarts detection and swallows the current bit.
  always_comb begin
    history_nx     = history;
    fill_nx        = fill;
    cfg_pattern_nx = cfg_pattern;
    cfg_len_nx     = cfg_len;
    cfg_overlap_nx = cfg_overlap;
    cfg_err_nx     = cfg_err;
    match_nx       = 1'b0;
    match_cnt_nx   = match_cnt;

    if (cfg_load) begin
      cfg_pattern_nx = pattern;
      cfg_len_nx     = pat_len;
      cfg_overlap_nx = overlap;
      cfg_err_nx     = (pat_len < MIN_LEN) || (pat_len > FULL_LEN);
      history_nx     = '0;
      fill_nx        = '0;
    end else if (in_valid) begin
      history_nx = shifted_c;
      // Non-overlapping mode needs cfg_len fresh bits after each hit.
      fill_nx    = (hit_c && !cfg_overlap) ? '0 : fill_inc_c;
      match_nx   = hit_c;
    end

    // Clear wins over a same-edge hit; the count saturates rather than wraps.
    if (clear) begin
      match_cnt_nx = '0;
    end else if (hit_c && (match_cnt != CNT_MAX)) begin
      match_cnt_nx = match_cnt + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history     <= '0;
      fill        <= '0;
      cfg_pattern <= '0;
      cfg_len     <= RST_LEN;
      cfg_overlap <= 1'b1;
      cfg_err     <= 1'b0;
      match       <= 1'b0;
      match_cnt   <= '0;
    end else begin
      history     <= history_nx;
      fill        <= fill_nx;
      cfg_pattern <= cfg_pattern_nx;
      cfg_len     <= cfg_len_nx;
      cfg_overlap <= cfg_overlap_nx;
      cfg_err     <= cfg_err_nx;
      match       <= match_nx;
      match_cnt   <= match_cnt_nx;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: the driver pushes the expected
// post-edge outputs for every cycle it drives, a monitor pops and compares.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_bit;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               clear;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;
  logic               match2;
  logic [1:0]         match_cnt2;
  logic               cfg_err2;

  typedef struct {
    logic m;
    int   c;
    int   c2;
    logic e;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clear(clear),
    .match(match), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clear(clear),
    .match(match2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  function automatic void check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // One cycle of stimulus plus the outputs expected after the next rising edge.
  task automatic drive(input logic r, input logic i, input logic v, input logic ld,
                       input logic clr, input logic em, input int ec, input int ec2);
    exp_t x;
    @(negedge clk);
    rst = r; in_bit = i; in_valid = v; cfg_load = ld; clear = clr;
    x.m = em; x.c = ec; x.c2 = ec2; x.e = r ? exp_err : 1'b0;
    sb.push_back(x);
  endtask

  task automatic bit_in(input logic i, input logic em, input int ec, input int ec2);
    drive(1'b1, i, 1'b1, 1'b0, 1'b0, em, ec, ec2);
  endtask

  task automatic idle(input int ec, input int ec2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, ec2);
  endtask

  // The bit presented alongside the load must be discarded.
  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic ov, input logic clr, input logic ee,
                      input int ec, input int ec2);
    pattern = p; pat_len = l; overlap = ov; exp_err = ee;
    drive(1'b1, 1'b1, 1'b1, 1'b1, clr, 1'b0, ec, ec2);
  endtask

  // Monitor: compare both instances against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("match",        int'(match),      int'(e.m));
        check("match_cnt",    int'(match_cnt),  e.c);
        check("cfg_err",      int'(cfg_err),    int'(e.e));
        check("match_w2",     int'(match2),     int'(e.m));
        check("match_cnt_w2", int'(match_cnt2), e.c2);
        check("cfg_err_w2",   int'(cfg_err2),   int'(e.e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    pattern = '0; pat_len = LEN_W'(4); overlap = 1'b1; clear = 1'b0;

    // Reset state
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Overlapping 0110 over 0,1,1,0,1,1,0: hits after bits 4 and 7
    load(8'b0000_0110, 4'd4, 1'b1, 1'b1, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
    bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(0, 1, 2, 2);
    idle(2, 2);

    // Non-overlapping: single hit after bit 4
    load(8'b0000_0110, 4'd4, 1'b0, 1'b1, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
    bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(0, 0, 1, 1);
    idle(1, 1);

    // Gaps of 3 invalid cycles (in held at 1) are transparent
    load(8'b0000_0110, 4'd4, 1'b1, 1'b1, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    bit_in(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    bit_in(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    bit_in(0, 1, 1, 1);
    idle(1, 1);

    // Illegal lengths 0 and 9 disable detection; legal reload clears cfg_err
    load(8'b0000_0000, 4'd0, 1'b1, 1'b1, 1'b1, 0, 0);
    for (int k = 0; k < 4; k++) bit_in(0, 0, 0, 0);
    load(8'b0000_0110, 4'd9, 1'b1, 1'b0, 1'b1, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    load(8'b0000_0110, 4'd4, 1'b1, 1'b0, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
    idle(1, 1);

    // Pattern 11, six 1s: 5 hits, 2-bit counter saturates at 3; then clear vs hit
    load(8'b1111_0011, 4'd2, 1'b1, 1'b1, 1'b0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 1, 1, 1); bit_in(1, 1, 2, 2);
    bit_in(1, 1, 3, 3); bit_in(1, 1, 4, 3); bit_in(1, 1, 5, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    bit_in(1, 1, 1, 1);
    idle(1, 1);

    // Reset mid-pattern: full restart, config back to pattern 0 / len 4
    load(8'b0000_0110, 4'd4, 1'b1, 1'b0, 1'b0, 1, 1);
    bit_in(0, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 1, 1, 1);
    load(8'b0000_0110, 4'd4, 1'b1, 1'b1, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
    idle(1, 1);
    idle(1, 1);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
